// File: rtl/ltc2600_pkg.sv
// Shared command codes, address width and sequencer state encoding for the LTC2600 path.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package ltc2600_pkg;

    // LTC2600 command nibbles
    localparam logic [3:0] WRITE_TO_REG_N       = 4'b0000;
    localparam logic [3:0] POWER_UP_REG_N       = 4'b0001;
    localparam logic [3:0] WRITE_TO_N_POWER_ALL = 4'b0010;
    localparam logic [3:0] WRITE_TO_N_POWER_N   = 4'b0011;
    localparam logic [3:0] POWER_DOWN_N         = 4'b0100;
    localparam logic [3:0] NO_OPERATION         = 4'b1111;

    // Width of the address field in the serial frame
    localparam int DAC_ADDR_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_GAP  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request strictly after ptr, wrapping modulo N.
// Latency: combinational.
// Backpressure: none; the caller decides whether to act on the grant.
module rr_arbiter #(
    parameter int N = 8
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 grant_valid
);

    localparam int W = $clog2(N);

    logic [W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest pending channel wins last.
    // Offset N truncates to 0, i.e. ptr itself is considered with the lowest priority.
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int i = N; i >= 1; i--) begin
            idx = ptr + W'(i);
            if (req[idx]) begin
                grant_idx   = idx;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ltc2600_sequencer.sv
// Per-channel shadow/pending store feeding the LTC2600 writer one transaction at a time, round-robin.
// Latency: request sampled at edge E (idle, enabled) -> dac_send_new_cmd at E+1; one GAP cycle after each completion.
// Backpressure: only one transaction in flight; new requests coalesce in the shadow until issued; WAIT bounded by timeout.
module ltc2600_sequencer
    import ltc2600_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_CH         = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        enable,
    input  logic                        cfg_wr_en,
    input  logic [$clog2(NUM_CH)-1:0]   cfg_ch,
    input  logic [DATA_WIDTH-1:0]       cfg_data,
    input  logic                        cfg_pd_en,
    input  logic                        clear_err,
    input  logic [$clog2(NUM_CH)-1:0]   rd_ch,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic                        dac_send_new_cmd,
    output logic [3:0]                  dac_command,
    output logic [DAC_ADDR_W-1:0]       dac_address,
    output logic [DATA_WIDTH-1:0]       dac_data,
    input  logic                        dac_write_complete,
    output logic                        busy,
    output logic [NUM_CH-1:0]           wr_pending,
    output logic [NUM_CH-1:0]           pd_pending,
    output logic                        timeout_err
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    seq_state_t              state;
    logic [CH_W-1:0]         rr_ptr;
    logic [CNT_W-1:0]        cnt;
    logic [DATA_WIDTH-1:0]   shadow [NUM_CH];
    logic [CH_W-1:0]         grant_idx;
    logic                    grant_valid;
    logic                    issue;
    logic                    timeout_hit;

    rr_arbiter #(
        .N (NUM_CH)
    ) u_arb (
        .req         (wr_pending | pd_pending),
        .ptr         (rr_ptr),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign issue       = (state == ST_IDLE) && enable && grant_valid;
    assign timeout_hit = (state == ST_WAIT) && !dac_write_complete && (cnt == CNT_LAST);
    assign busy        = (state != ST_IDLE);
    assign rd_data     = shadow[rd_ch];

    // Capture cfg strobes into shadow/pending; a strobe in the issue cycle overrides the clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_pending <= '0;
            pd_pending <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            if (issue) begin
                wr_pending[grant_idx] <= 1'b0;
                pd_pending[grant_idx] <= 1'b0;
            end
            if (cfg_wr_en) begin
                shadow[cfg_ch]     <= cfg_data;
                wr_pending[cfg_ch] <= 1'b1;
                pd_pending[cfg_ch] <= 1'b0;
            end else if (cfg_pd_en) begin
                pd_pending[cfg_ch] <= 1'b1;
                wr_pending[cfg_ch] <= 1'b0;
            end
        end
    end

    // Issue / wait / gap sequencing and the registered writer-facing outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state            <= ST_IDLE;
            rr_ptr           <= CH_W'(NUM_CH - 1);
            cnt              <= '0;
            dac_send_new_cmd <= 1'b0;
            dac_command      <= NO_OPERATION;
            dac_address      <= '0;
            dac_data         <= '0;
        end else begin
            dac_send_new_cmd <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        rr_ptr           <= grant_idx;
                        cnt              <= '0;
                        dac_send_new_cmd <= 1'b1;
                        dac_address      <= DAC_ADDR_W'(grant_idx);
                        if (wr_pending[grant_idx]) begin
                            dac_command <= WRITE_TO_N_POWER_N;
                            dac_data    <= shadow[grant_idx];
                        end else begin
                            dac_command <= POWER_DOWN_N;
                            dac_data    <= '0;
                        end
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (dac_write_complete || (cnt == CNT_LAST)) begin
                        state <= ST_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky timeout flag; a timeout in the same cycle as clear_err keeps it set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            timeout_err <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err <= 1'b1;
        end else if (clear_err) begin
            timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ltc2600_sequencer.sv
// Directed bench for ltc2600_sequencer with a simple writer model that answers each start pulse.
// Latency: writer model completes 5 cycles after seeing a pulse unless told to hang.
// Backpressure: n/a.
module tb_ltc2600_sequencer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    logic        cfg_wr_en = 1'b0;
    logic [2:0]  cfg_ch = '0;
    logic [15:0] cfg_data = '0;
    logic        cfg_pd_en = 1'b0;
    logic        clear_err = 1'b0;
    logic [2:0]  rd_ch = '0;
    logic [15:0] rd_data;
    logic        dac_send_new_cmd;
    logic [3:0]  dac_command;
    logic [3:0]  dac_address;
    logic [15:0] dac_data;
    logic        dac_write_complete = 1'b0;
    logic        busy;
    logic [7:0]  wr_pending;
    logic [7:0]  pd_pending;
    logic        timeout_err;

    ltc2600_sequencer #(
        .DATA_WIDTH     (16),
        .NUM_CH         (8),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk                (clk),
        .rstn               (rstn),
        .enable             (enable),
        .cfg_wr_en          (cfg_wr_en),
        .cfg_ch             (cfg_ch),
        .cfg_data           (cfg_data),
        .cfg_pd_en          (cfg_pd_en),
        .clear_err          (clear_err),
        .rd_ch              (rd_ch),
        .rd_data            (rd_data),
        .dac_send_new_cmd   (dac_send_new_cmd),
        .dac_command        (dac_command),
        .dac_address        (dac_address),
        .dac_data           (dac_data),
        .dac_write_complete (dac_write_complete),
        .busy               (busy),
        .wr_pending         (wr_pending),
        .pd_pending         (pd_pending),
        .timeout_err        (timeout_err)
    );

    always #10 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Writer model: logs each pulse, checks pulse width and spacing, answers with a complete pulse.
    logic [3:0]  q_cmd  [$];
    logic [3:0]  q_addr [$];
    logic [15:0] q_data [$];
    int   npulse    = 0;
    int   countdown = 0;
    int   low_run   = 100;
    logic prev_hi   = 1'b0;
    logic hang      = 1'b0;

    always @(negedge clk) begin
        if (!rstn) begin
            countdown          = 0;
            dac_write_complete = 1'b0;
            low_run            = 100;
            prev_hi            = 1'b0;
        end else begin
            dac_write_complete = 1'b0;
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0 && !hang) dac_write_complete = 1'b1;
            end
            if (dac_send_new_cmd) begin
                chk("pulse_width", {31'd0, prev_hi}, 32'd0);
                if (!prev_hi) begin
                    chk("pulse_gap", {31'd0, low_run >= 2}, 32'd1);
                    q_cmd.push_back(dac_command);
                    q_addr.push_back(dac_address);
                    q_data.push_back(dac_data);
                    npulse++;
                    countdown = 5;
                end
                low_run = 0;
                prev_hi = 1'b1;
            end else begin
                low_run++;
                prev_hi = 1'b0;
            end
        end
    end

    task automatic op(input logic wr, input logic pd, input logic [2:0] ch, input logic [15:0] d);
        cfg_wr_en = wr;
        cfg_pd_en = pd;
        cfg_ch    = ch;
        cfg_data  = d;
        @(negedge clk);
        cfg_wr_en = 1'b0;
        cfg_pd_en = 1'b0;
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        enable    = 1'b0;
        cfg_wr_en = 1'b0;
        cfg_pd_en = 1'b0;
        clear_err = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int target);
        int k = 0;
        while ((npulse < target || busy) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("wait_npulse", npulse, target);
    endtask

    typedef struct {
        logic        wr1;
        logic        pd1;
        logic [2:0]  ch;
        logic [15:0] d1;
        logic        wr2;
        logic        pd2;
        logic [15:0] d2;
        logic [3:0]  ecmd;
        logic [15:0] edata;
        logic [15:0] erd;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int base;
        int k;
        logic [7:0] onehot;

        tbl[0] = '{1'b1, 1'b0, 3'd3, 16'hABCD, 1'b0, 1'b0, 16'h0000, 4'b0011, 16'hABCD, 16'hABCD};
        tbl[1] = '{1'b1, 1'b0, 3'd2, 16'h1111, 1'b1, 1'b0, 16'h2222, 4'b0011, 16'h2222, 16'h2222};
        tbl[2] = '{1'b0, 1'b1, 3'd4, 16'h0000, 1'b1, 1'b0, 16'h0800, 4'b0011, 16'h0800, 16'h0800};
        tbl[3] = '{1'b1, 1'b0, 3'd6, 16'h5555, 1'b0, 1'b1, 16'h0000, 4'b0100, 16'h0000, 16'h5555};
        tbl[4] = '{1'b1, 1'b1, 3'd1, 16'h1234, 1'b0, 1'b0, 16'h0000, 4'b0011, 16'h1234, 16'h1234};
        tbl[5] = '{1'b0, 1'b1, 3'd7, 16'h0000, 1'b0, 1'b0, 16'h0000, 4'b0100, 16'h0000, 16'h0000};
        tbl[6] = '{1'b1, 1'b0, 3'd0, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 4'b0011, 16'hFFFF, 16'hFFFF};

        // Reset values while rstn is held low
        repeat (3) @(negedge clk);
        chk("rst_send", {31'd0, dac_send_new_cmd}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, timeout_err}, 32'd0);
        chk("rst_cmd", {28'd0, dac_command}, 32'hF);
        chk("rst_addr", {28'd0, dac_address}, 32'd0);
        chk("rst_data", {16'd0, dac_data}, 32'd0);
        chk("rst_wrp", {24'd0, wr_pending}, 32'd0);
        chk("rst_pdp", {24'd0, pd_pending}, 32'd0);
        chk("rst_rd", {16'd0, rd_data}, 32'd0);
        rstn   = 1'b1;
        enable = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_no_pulse", npulse, 0);

        // Single write: pulse one edge after capture, busy timeline around completion
        base = npulse;
        op(1'b1, 1'b0, 3'd3, 16'hABCD);
        chk("lat_not_yet", {31'd0, dac_send_new_cmd}, 32'd0);
        @(negedge clk);
        chk("lat_pulse", {31'd0, dac_send_new_cmd}, 32'd1);
        chk("lat_busy", {31'd0, busy}, 32'd1);
        chk("lat_cmd", {28'd0, dac_command}, 32'h3);
        chk("lat_addr", {28'd0, dac_address}, 32'h3);
        chk("lat_data", {16'd0, dac_data}, 32'hABCD);
        @(negedge clk);
        chk("lat_pulse_low", {31'd0, dac_send_new_cmd}, 32'd0);
        k = 0;
        do begin
            @(posedge clk);
            k++;
        end while (!dac_write_complete && k < 100);
        chk("lat_complete_seen", {31'd0, dac_write_complete}, 32'd1);
        @(negedge clk);
        chk("gap_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("lat_hold_data", {16'd0, dac_data}, 32'hABCD);
        rd_ch = 3'd3;
        #1;
        chk("lat_rd", {16'd0, rd_data}, 32'hABCD);
        chk("lat_count", npulse, base + 1);

        // Table: one or two strobes with enable low, then exactly one transaction expected
        for (int v = 0; v < 7; v++) begin
            enable = 1'b0;
            op(tbl[v].wr1, tbl[v].pd1, tbl[v].ch, tbl[v].d1);
            op(tbl[v].wr2, tbl[v].pd2, tbl[v].ch, tbl[v].d2);
            onehot = 8'd1 << tbl[v].ch;
            chk($sformatf("v%0d_wrp", v), {24'd0, wr_pending}, (tbl[v].ecmd == 4'b0011) ? {24'd0, onehot} : 32'd0);
            chk($sformatf("v%0d_pdp", v), {24'd0, pd_pending}, (tbl[v].ecmd == 4'b0100) ? {24'd0, onehot} : 32'd0);
            rd_ch = tbl[v].ch;
            #1;
            chk($sformatf("v%0d_rd", v), {16'd0, rd_data}, {16'd0, tbl[v].erd});
            base   = npulse;
            enable = 1'b1;
            wait_idle(base + 1);
            repeat (10) @(negedge clk);
            enable = 1'b0;
            chk($sformatf("v%0d_count", v), npulse, base + 1);
            chk($sformatf("v%0d_cmd", v), {28'd0, q_cmd[base]}, {28'd0, tbl[v].ecmd});
            chk($sformatf("v%0d_addr", v), {28'd0, q_addr[base]}, {29'd0, tbl[v].ch});
            chk($sformatf("v%0d_data", v), {16'd0, q_data[base]}, {16'd0, tbl[v].edata});
            chk($sformatf("v%0d_clr", v), {24'd0, wr_pending | pd_pending}, 32'd0);
        end

        // Round-robin order from reset pointer: 0, 5, 7
        do_reset();
        op(1'b1, 1'b0, 3'd5, 16'h5000);
        op(1'b1, 1'b0, 3'd0, 16'h0A0A);
        op(1'b1, 1'b0, 3'd7, 16'h7000);
        base   = npulse;
        enable = 1'b1;
        wait_idle(base + 3);
        chk("rr_first", {28'd0, q_addr[base]}, 32'd0);
        chk("rr_second", {28'd0, q_addr[base + 1]}, 32'd5);
        chk("rr_third", {28'd0, q_addr[base + 2]}, 32'd7);
        chk("rr_third_data", {16'd0, q_data[base + 2]}, 32'h7000);

        // Write to the in-flight channel during WAIT produces a second transaction
        do_reset();
        enable = 1'b1;
        base   = npulse;
        op(1'b1, 1'b0, 3'd2, 16'h2222);
        k = 0;
        while (npulse < base + 1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("inflight_busy", {31'd0, busy}, 32'd1);
        op(1'b1, 1'b0, 3'd2, 16'h3333);
        wait_idle(base + 2);
        chk("inflight_first", {16'd0, q_data[base]}, 32'h2222);
        chk("inflight_second", {16'd0, q_data[base + 1]}, 32'h3333);

        // Timeout: writer hangs on ch1, then ch2 is issued; clear_err drops the flag
        do_reset();
        op(1'b1, 1'b0, 3'd1, 16'h0101);
        op(1'b1, 1'b0, 3'd2, 16'h0202);
        hang   = 1'b1;
        base   = npulse;
        enable = 1'b1;
        k = 0;
        while (!dac_send_new_cmd && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("to_pulse", {31'd0, dac_send_new_cmd}, 32'd1);
        repeat (63) @(negedge clk);
        chk("to_err_early", {31'd0, timeout_err}, 32'd0);
        chk("to_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("to_err_set", {31'd0, timeout_err}, 32'd1);
        hang = 1'b0;
        wait_idle(base + 2);
        chk("to_first_addr", {28'd0, q_addr[base]}, 32'd1);
        chk("to_next_addr", {28'd0, q_addr[base + 1]}, 32'd2);
        chk("to_next_data", {16'd0, q_data[base + 1]}, 32'h0202);
        chk("to_err_sticky", {31'd0, timeout_err}, 32'd1);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        chk("to_err_clear", {31'd0, timeout_err}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
